// File: rtl/spike_frame_parser.sv
// Spike frame parser: drains the spike FIFO, strips SOF/EOF markers and
// streams payload words with first/last flags, frame length and error reports.
module spike_frame_parser #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] SOF       = 16'hFAF1,
  parameter logic [WIDTH-1:0] EOF       = 16'hF1FA,
  parameter int unsigned      MAX_LEN   = 256,
  parameter int unsigned      LEN_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [WIDTH-1:0]     fifo_rd_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_first,
  output logic                 m_last,
  output logic                 frame_done,
  output logic [LEN_WIDTH-1:0] frame_len,
  output logic                 frame_err,
  output logic [1:0]           err_cause
);

  localparam logic [0:0] HUNT    = 1'b0;
  localparam logic [0:0] PAYLOAD = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [WIDTH-1:0]     pending_q, pending_d;
  logic                 pending_valid_q, pending_valid_d;
  logic                 first_pending_q, first_pending_d;
  logic                 rd_inflight_q;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic                 m_valid_d, m_first_d, m_last_d;
  logic [WIDTH-1:0]     m_data_d;
  logic                 frame_done_d, frame_err_d;
  logic [LEN_WIDTH-1:0] frame_len_d;
  logic [1:0]           err_cause_d;

  // Only issue a read when the output slot will be free on data return.
  assign fifo_rd_en = !fifo_empty && !rd_inflight_q && (!m_valid || m_ready);

  // Next-state: one word is evaluated in the cycle after our own read strobe.
  always_comb begin
    state_d         = state_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    first_pending_d = first_pending_q;
    cnt_d           = cnt_q;
    m_valid_d       = m_valid;
    m_data_d        = m_data;
    m_first_d       = m_first;
    m_last_d        = m_last;
    frame_done_d    = 1'b0;
    frame_len_d     = frame_len;
    frame_err_d     = 1'b0;
    err_cause_d     = err_cause;

    if (m_valid && m_ready) begin
      m_valid_d = 1'b0;
      m_data_d  = '0;
      m_first_d = 1'b0;
      m_last_d  = 1'b0;
    end

    if (rd_inflight_q) begin
      case (state_q)
        HUNT: begin
          if (fifo_rd_data == SOF) begin
            state_d         = PAYLOAD;
            cnt_d           = '0;
            pending_valid_d = 1'b0;
            first_pending_d = 1'b1;
          end
        end
        default: begin
          if (fifo_rd_data == SOF) begin
            frame_err_d     = 1'b1;
            err_cause_d     = 2'b01;
            pending_valid_d = 1'b0;
            cnt_d           = '0;
            first_pending_d = 1'b1;
          end else if (fifo_rd_data == EOF) begin
            if (pending_valid_q) begin
              m_valid_d = 1'b1;
              m_data_d  = pending_q;
              m_first_d = first_pending_q;
              m_last_d  = 1'b1;
            end
            frame_done_d    = 1'b1;
            frame_len_d     = cnt_q;
            pending_valid_d = 1'b0;
            state_d         = HUNT;
          end else if (cnt_q == LEN_WIDTH'(MAX_LEN)) begin
            frame_err_d     = 1'b1;
            err_cause_d     = 2'b10;
            pending_valid_d = 1'b0;
            state_d         = HUNT;
          end else begin
            // Lookahead: a word is released only once its successor is known.
            if (pending_valid_q) begin
              m_valid_d       = 1'b1;
              m_data_d        = pending_q;
              m_first_d       = first_pending_q;
              m_last_d        = 1'b0;
              first_pending_d = 1'b0;
            end
            pending_d       = fifo_rd_data;
            pending_valid_d = 1'b1;
            cnt_d           = cnt_q + LEN_WIDTH'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= HUNT;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      first_pending_q <= 1'b0;
      rd_inflight_q   <= 1'b0;
      cnt_q           <= '0;
      m_valid         <= 1'b0;
      m_data          <= '0;
      m_first         <= 1'b0;
      m_last          <= 1'b0;
      frame_done      <= 1'b0;
      frame_len       <= '0;
      frame_err       <= 1'b0;
      err_cause       <= 2'b00;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      first_pending_q <= first_pending_d;
      rd_inflight_q   <= fifo_rd_en;
      cnt_q           <= cnt_d;
      m_valid         <= m_valid_d;
      m_data          <= m_data_d;
      m_first         <= m_first_d;
      m_last          <= m_last_d;
      frame_done      <= frame_done_d;
      frame_len       <= frame_len_d;
      frame_err       <= frame_err_d;
      err_cause       <= err_cause_d;
    end
  end

endmodule

// File: tb/tb_spike_frame_parser.sv
// Directed bench for spike_frame_parser with a behavioural registered-read FIFO.
module tb_spike_frame_parser;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned LEN_WIDTH = 9;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b1;
  logic                 fifo_empty;
  logic                 fifo_rd_en;
  logic [WIDTH-1:0]     fifo_rd_data = '0;
  logic                 m_valid;
  logic                 m_ready = 1'b1;
  logic [WIDTH-1:0]     m_data;
  logic                 m_first;
  logic                 m_last;
  logic                 frame_done;
  logic [LEN_WIDTH-1:0] frame_len;
  logic                 frame_err;
  logic [1:0]           err_cause;

  int vectors    = 0;
  int miscompares = 0;

  spike_frame_parser dut (
    .clk          (clk),
    .rstn         (rstn),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_first      (m_first),
    .m_last       (m_last),
    .frame_done   (frame_done),
    .frame_len    (frame_len),
    .frame_err    (frame_err),
    .err_cause    (err_cause)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read port, flushed together with the parser reset.
  logic [WIDTH-1:0] mem [0:1023];
  int pushed = 0;
  int popped = 0;
  assign fifo_empty = (popped == pushed);

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      popped       <= pushed;
      fifo_rd_data <= '0;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= mem[popped];
      popped       <= popped + 1;
    end
  end

  // Event logs sampled on the falling edge.
  logic [WIDTH-1:0]     bd [0:511];
  logic                 bf [0:511];
  logic                 bl [0:511];
  logic [LEN_WIDTH-1:0] dl [0:63];
  logic                 dlast [0:63];
  logic [1:0]           ec [0:63];
  int nb = 0, nd = 0, ne = 0;

  always @(negedge clk) begin
    if (rstn) begin
      if (m_valid && m_ready) begin
        bd[nb] = m_data; bf[nb] = m_first; bl[nb] = m_last; nb++;
      end
      if (frame_done) begin
        dl[nd] = frame_len; dlast[nd] = m_valid && m_last; nd++;
      end
      if (frame_err) begin
        ec[ne] = err_cause; ne++;
      end
    end
  end

  task automatic push(input logic [WIDTH-1:0] w);
    mem[pushed] = w;
    pushed++;
  endtask

  task automatic drain(output bit timed_out);
    int quiet = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (fifo_empty && !m_valid) quiet++; else quiet = 0;
      if (quiet >= 4) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++; if (fifo_rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
    vectors++; if ({m_valid, m_first, m_last} !== 3'b000) begin miscompares++; $display("FAIL reset_beat_flags: got %b expected 000", {m_valid, m_first, m_last}); end
    vectors++; if (m_data !== 16'h0000) begin miscompares++; $display("FAIL reset_m_data: got %h expected 0000", m_data); end
    vectors++; if ({frame_done, frame_err} !== 2'b00) begin miscompares++; $display("FAIL reset_pulses: got %b expected 00", {frame_done, frame_err}); end
    vectors++; if (frame_len !== 9'd0) begin miscompares++; $display("FAIL reset_frame_len: got %0d expected 0", frame_len); end
    vectors++; if (err_cause !== 2'b00) begin miscompares++; $display("FAIL reset_err_cause: got %b expected 00", err_cause); end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int b0 = nb, d0 = nd, e0 = ne, lat = -1;
    bit to;
    m_ready = 1'b1;
    push(16'hFAF1); push(16'h0011); push(16'h0022); push(16'h0033); push(16'hF1FA);
    #1;
    vectors++; if (fifo_rd_en !== 1'b1) begin miscompares++; $display("FAIL basic_first_rd: got %b expected 1", fifo_rd_en); end
    for (int i = 0; i < 40; i++) begin
      if (frame_done) begin lat = i; break; end
      @(posedge clk); #1;
    end
    vectors++; if (lat != 10) begin miscompares++; $display("FAIL basic_latency: got %0d expected 10 cycles", lat); end
    drain(to);
    vectors++; if (to) begin miscompares++; $display("FAIL basic_drain: got timeout expected idle"); end
    vectors++; if (nb - b0 != 3) begin miscompares++; $display("FAIL basic_beats: got %0d expected 3", nb - b0); end
    vectors++; if ({bd[b0], bf[b0], bl[b0]} !== {16'h0011, 2'b10}) begin miscompares++; $display("FAIL basic_beat0: got %h/%b%b expected 0011/10", bd[b0], bf[b0], bl[b0]); end
    vectors++; if ({bd[b0+1], bf[b0+1], bl[b0+1]} !== {16'h0022, 2'b00}) begin miscompares++; $display("FAIL basic_beat1: got %h/%b%b expected 0022/00", bd[b0+1], bf[b0+1], bl[b0+1]); end
    vectors++; if ({bd[b0+2], bf[b0+2], bl[b0+2]} !== {16'h0033, 2'b01}) begin miscompares++; $display("FAIL basic_beat2: got %h/%b%b expected 0033/01", bd[b0+2], bf[b0+2], bl[b0+2]); end
    vectors++; if (nd - d0 != 1 || dl[d0] !== 9'd3) begin miscompares++; $display("FAIL basic_done: got %0d dones len %0d expected 1 len 3", nd - d0, dl[d0]); end
    vectors++; if (dlast[d0] !== 1'b1) begin miscompares++; $display("FAIL basic_done_with_last: got %b expected 1", dlast[d0]); end
    vectors++; if (ne - e0 != 0) begin miscompares++; $display("FAIL basic_no_err: got %0d errors expected 0", ne - e0); end
    vectors++; if (frame_len !== 9'd3) begin miscompares++; $display("FAIL basic_len_held: got %0d expected 3", frame_len); end
  endtask

  task automatic test_hunt_empty();
    int b0 = nb, d0 = nd;
    bit to;
    push(16'h1234); push(16'hFAF1); push(16'hF1FA);
    drain(to);
    vectors++; if (to) begin miscompares++; $display("FAIL hunt_drain: got timeout expected idle"); end
    vectors++; if (nb - b0 != 0) begin miscompares++; $display("FAIL hunt_beats: got %0d expected 0", nb - b0); end
    vectors++; if (nd - d0 != 1 || dl[d0] !== 9'd0) begin miscompares++; $display("FAIL hunt_empty_done: got %0d dones len %0d expected 1 len 0", nd - d0, dl[d0]); end
  endtask

  task automatic test_nested_sof();
    int b0 = nb, d0 = nd, e0 = ne;
    bit to;
    push(16'hFAF1); push(16'h00AA); push(16'hFAF1); push(16'h00BB); push(16'hF1FA);
    drain(to);
    vectors++; if (to) begin miscompares++; $display("FAIL nested_drain: got timeout expected idle"); end
    vectors++; if (ne - e0 != 1 || ec[e0] !== 2'b01) begin miscompares++; $display("FAIL nested_err: got %0d errs cause %b expected 1 cause 01", ne - e0, ec[e0]); end
    vectors++; if (nb - b0 != 1 || {bd[b0], bf[b0], bl[b0]} !== {16'h00BB, 2'b11}) begin miscompares++; $display("FAIL nested_beat: got %0d beats %h/%b%b expected 1 beat 00BB/11", nb - b0, bd[b0], bf[b0], bl[b0]); end
    vectors++; if (nd - d0 != 1 || dl[d0] !== 9'd1) begin miscompares++; $display("FAIL nested_done: got %0d dones len %0d expected 1 len 1", nd - d0, dl[d0]); end
    vectors++; if (err_cause !== 2'b01) begin miscompares++; $display("FAIL nested_cause_held: got %b expected 01", err_cause); end
  endtask

  task automatic test_overflow();
    int b0 = nb, d0 = nd, e0 = ne;
    bit to;
    push(16'hFAF1);
    for (int i = 1; i <= 257; i++) push(16'(i));
    drain(to);
    vectors++; if (to) begin miscompares++; $display("FAIL ovf_drain: got timeout expected idle"); end
    vectors++; if (ne - e0 != 1 || ec[e0] !== 2'b10) begin miscompares++; $display("FAIL ovf_err: got %0d errs cause %b expected 1 cause 10", ne - e0, ec[e0]); end
    vectors++; if (nb - b0 != 255) begin miscompares++; $display("FAIL ovf_beats: got %0d expected 255", nb - b0); end
    vectors++; if ({bd[b0], bf[b0]} !== {16'h0001, 1'b1}) begin miscompares++; $display("FAIL ovf_first: got %h/%b expected 0001/1", bd[b0], bf[b0]); end
    vectors++; if ({bd[b0+254], bl[b0+254]} !== {16'h00FF, 1'b0}) begin miscompares++; $display("FAIL ovf_tail: got %h/%b expected 00FF/0", bd[b0+254], bl[b0+254]); end
    vectors++; if (nd - d0 != 0) begin miscompares++; $display("FAIL ovf_no_done: got %0d expected 0", nd - d0); end
    // Back in HUNT: a stray word and EOF must both be discarded.
    push(16'h0055); push(16'hF1FA);
    drain(to);
    vectors++; if (to || nd - d0 != 0 || nb - b0 != 255) begin miscompares++; $display("FAIL ovf_hunt: got to=%b dones %0d beats %0d expected 0/0/255", to, nd - d0, nb - b0); end
  endtask

  task automatic test_stall();
    int b0 = nb, d0 = nd;
    bit to, seen = 1'b0, bad = 1'b0;
    m_ready = 1'b0;
    push(16'hFAF1); push(16'h0077); push(16'hF1FA); push(16'h0000);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (m_valid) begin seen = 1'b1; break; end
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL stall_valid: got no beat expected one within 40 cycles"); end
    vectors++; if ({m_first, m_last} !== 2'b11) begin miscompares++; $display("FAIL stall_flags: got %b expected 11", {m_first, m_last}); end
    for (int i = 0; i < 10; i++) begin
      if (m_valid !== 1'b1 || m_data !== 16'h0077 || fifo_rd_en !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    vectors++; if (bad) begin miscompares++; $display("FAIL stall_hold: got unstable beat or read expected 0077 held, rd_en 0"); end
    m_ready = 1'b1;
    drain(to);
    vectors++; if (to || nb - b0 != 1 || bd[b0] !== 16'h0077) begin miscompares++; $display("FAIL stall_accept: got to=%b %0d beats %h expected 1 beat 0077", to, nb - b0, bd[b0]); end
    vectors++; if (nd - d0 != 1 || dl[d0] !== 9'd1) begin miscompares++; $display("FAIL stall_done: got %0d dones len %0d expected 1 len 1", nd - d0, dl[d0]); end
  endtask

  task automatic test_reset_midframe();
    int b0 = nb, d0 = nd, b1, d1;
    bit to, got2 = 1'b0;
    m_ready = 1'b1;
    push(16'hFAF1); push(16'h0101); push(16'h0202); push(16'h0303);
    push(16'h0404); push(16'h0505); push(16'hF1FA);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (nb - b0 >= 2) begin got2 = 1'b1; break; end
    end
    vectors++; if (!got2) begin miscompares++; $display("FAIL midrst_two_beats: got %0d beats expected 2", nb - b0); end
    rstn = 1'b0;
    #1;
    vectors++; if ({fifo_rd_en, m_valid, m_first, m_last, frame_done, frame_err} !== 6'b0) begin miscompares++; $display("FAIL midrst_flags: got %b expected 000000", {fifo_rd_en, m_valid, m_first, m_last, frame_done, frame_err}); end
    vectors++; if ({m_data, frame_len, err_cause} !== 27'd0) begin miscompares++; $display("FAIL midrst_values: got %h/%0d/%b expected 0000/0/00", m_data, frame_len, err_cause); end
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    vectors++; if (nd - d0 != 0) begin miscompares++; $display("FAIL midrst_no_done: got %0d expected 0", nd - d0); end
    b1 = nb; d1 = nd;
    push(16'hFAF1); push(16'h0A0A); push(16'h0B0B); push(16'hF1FA);
    drain(to);
    vectors++; if (to || nb - b1 != 2) begin miscompares++; $display("FAIL midrst_beats: got to=%b %0d beats expected 2", to, nb - b1); end
    vectors++; if ({bd[b1], bf[b1], bl[b1], bd[b1+1], bf[b1+1], bl[b1+1]} !== {16'h0A0A, 2'b10, 16'h0B0B, 2'b01}) begin miscompares++; $display("FAIL midrst_frame: got %h/%b%b %h/%b%b expected 0A0A/10 0B0B/01", bd[b1], bf[b1], bl[b1], bd[b1+1], bf[b1+1], bl[b1+1]); end
    vectors++; if (nd - d1 != 1 || dl[d1] !== 9'd2) begin miscompares++; $display("FAIL midrst_done: got %0d dones len %0d expected 1 len 2", nd - d1, dl[d1]); end
  endtask

  task automatic test_back_to_back();
    int b0 = nb, d0 = nd, e0 = ne;
    bit to;
    push(16'hFAF1); push(16'h0001); push(16'hF1FA);
    push(16'hFAF1); push(16'h0002); push(16'h0003); push(16'hF1FA);
    drain(to);
    vectors++; if (to || nb - b0 != 3 || ne - e0 != 0) begin miscompares++; $display("FAIL b2b_counts: got to=%b beats %0d errs %0d expected 3 beats 0 errs", to, nb - b0, ne - e0); end
    vectors++; if ({bd[b0], bf[b0], bl[b0]} !== {16'h0001, 2'b11}) begin miscompares++; $display("FAIL b2b_beat0: got %h/%b%b expected 0001/11", bd[b0], bf[b0], bl[b0]); end
    vectors++; if ({bd[b0+1], bf[b0+1], bl[b0+1], bd[b0+2], bf[b0+2], bl[b0+2]} !== {16'h0002, 2'b10, 16'h0003, 2'b01}) begin miscompares++; $display("FAIL b2b_frame2: got %h/%b%b %h/%b%b expected 0002/10 0003/01", bd[b0+1], bf[b0+1], bl[b0+1], bd[b0+2], bf[b0+2], bl[b0+2]); end
    vectors++; if (nd - d0 != 2 || dl[d0] !== 9'd1 || dl[d0+1] !== 9'd2) begin miscompares++; $display("FAIL b2b_lens: got %0d dones lens %0d,%0d expected 2 dones lens 1,2", nd - d0, dl[d0], dl[d0+1]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hunt_empty();
    test_nested_sof();
    test_overflow();
    test_stall();
    test_reset_midframe();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spike_frame_parser.md
# spike_frame_parser

Downstream consumer of the 16-bit synchronous spike FIFO. It drains words through the FIFO's registered read port and delineates frames using the marker words 16'hFAF1 (start of frame) and 16'hF1FA (end of frame). Payload words go out on a valid/ready stream with first/last flags, and the block reports frame length and framing errors. It sits between the FIFO and the neuron-core input router.

## Interface
- WIDTH, 16, data word width
- SOF, 16'hFAF1, start-of-frame marker
- EOF, 16'hF1FA, end-of-frame marker
- MAX_LEN, 256, maximum payload words per frame
- LEN_WIDTH, 9, width of length counter; must hold MAX_LEN
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO read strobe; combinational from registered state, fifo_empty, m_valid, m_ready
- fifo_rd_data  in  WIDTH  FIFO registered read data; valid the cycle after fifo_rd_en
- m_valid  out  1  payload beat valid
- m_ready  in  1  downstream accept
- m_data  out  WIDTH  payload word
- m_first  out  1  first payload word of frame
- m_last  out  1  last payload word of frame
- frame_done  out  1  one-cycle pulse; a frame closed by EOF
- frame_len  out  LEN_WIDTH  payload count of last completed frame; held until next frame_done
- frame_err  out  1  one-cycle pulse; framing error
- err_cause  out  2  01 nested SOF, 10 length overflow; held until next frame_err

## Operation
- States: HUNT, PAYLOAD. Internal regs: pending word plus pending_valid, first_pending flag, rd_inflight, payload counter cnt.
- Read issue: fifo_rd_en = !fifo_empty && !rd_inflight && (!m_valid || m_ready). rd_inflight sets on issue and clears when data returns. At most one read is outstanding.
- fifo_rd_data is sampled only in the cycle after the block's own fifo_rd_en. At all other times it is ignored.
- HUNT: non-SOF words are discarded. SOF -> PAYLOAD with cnt=0, pending_valid=0, first_pending=1.
- PAYLOAD, data word (not SOF/EOF):
  - If cnt==MAX_LEN: frame_err with err_cause=10, pending dropped, -> HUNT.
  - Else, if pending_valid: emit pending with m_first=first_pending, m_last=0, then clear first_pending.
  - Then pending<=word, pending_valid=1, cnt<=cnt+1.
- PAYLOAD, EOF:
  - If pending_valid: emit pending with m_last=1, and m_first=first_pending.
  - frame_done pulse, frame_len<=cnt, -> HUNT.
  - Empty frame (cnt==0): frame_done with frame_len=0 and no beat.
- PAYLOAD, SOF: frame_err with err_cause=01, pending dropped, restart frame (cnt=0, first_pending=1), stay in PAYLOAD.
- Aborted frames (error after beats were emitted) end without m_last. Downstream aborts on frame_err.
- Emitted beat: m_valid, m_data, m_first and m_last are registered. They hold stable while m_valid && !m_ready, and clear on handshake unless a new beat loads the same edge.
- The read-issue rule guarantees the output slot is free when data returns, so no beat is overwritten.

## Timing
- Cycle N: fifo_rd_en=1. Cycle N+1: fifo_rd_data valid and evaluated. Cycle N+2: resulting m_valid, frame_done and frame_err are visible.
- A data word appears on m_data one word late because of the lookahead: it goes out when the following word (data or EOF) is processed.
- Throughput is at most one FIFO word per 2 cycles. The next read can issue in cycle N+2.
- frame_done and frame_err are high for exactly one cycle. frame_done and a beat with m_last=1 become visible in the same cycle.
- Reset values:
  - fifo_rd_en=0, m_valid=0, m_data=0, m_first=0, m_last=0.
  - frame_done=0, frame_len=0, frame_err=0, err_cause=0.
  - State HUNT, rd_inflight=0, pending_valid=0.
- Reset mid-frame discards all state. A read in flight at reset is ignored.
- fifo_empty going high mid-frame stalls the block with no timeout; state is retained.

## Test plan
- FIFO holds FAF1,0011,0022,0033,F1FA; m_ready=1 -> beats 0011(first), 0022, 0033(last); frame_done with frame_len=3.
- Words 1234,FAF1,F1FA -> 1234 discarded; frame_done with frame_len=0; no m_valid.
- FAF1,00AA,FAF1,00BB,F1FA -> frame_err with err_cause=01 and no beat for 00AA; then 00BB with first=1 and last=1; frame_len=1.
- SOF followed by MAX_LEN+1 data words -> MAX_LEN-1 beats, then frame_err with err_cause=10; state returns to HUNT.
- Single-word frame with m_ready held low 10 cycles -> m_data stable and fifo_rd_en=0 throughout; beat accepted when m_ready rises.
- Assert rstn low after 2 beats of a 5-word frame -> all outputs 0; the next complete frame parses correctly from HUNT.
